// File: rtl/fifo_token_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_token_ctrl_if
// Handshake and status bundle between the FIFO sequencing controller and its
// surroundings (producer, consumer, storage cells, full/empty detectors).
//
// Signals:
//   put_req / get_req   requests from producer / consumer
//   put_en_o / get_en_o one-hot per-cell write / read enables
//   put_ack / get_ack   acceptance of the request this cycle
//   f_o                 registered per-cell full flags
//   full / empty        derived from f_o
//   count               registered occupancy, 0..N_CELLS
//   ovf / udf           one-cycle pulses for refused put / get requests
//
// Modports:
//   master  drives the requests, observes everything else
//   slave   the controller side
// -----------------------------------------------------------------------------
interface fifo_token_ctrl_if #(
  parameter int N_CELLS = 16
);
  localparam int CW = $clog2(N_CELLS + 1);

  logic               put_req;
  logic               get_req;
  logic [N_CELLS-1:0] put_en_o;
  logic [N_CELLS-1:0] get_en_o;
  logic               put_ack;
  logic               get_ack;
  logic [N_CELLS-1:0] f_o;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic               ovf;
  logic               udf;

  modport master (
    output put_req, get_req,
    input  put_en_o, get_en_o, put_ack, get_ack,
    input  f_o, full, empty, count, ovf, udf
  );

  modport slave (
    input  put_req, get_req,
    output put_en_o, get_en_o, put_ack, get_ack,
    output f_o, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/fifo_token_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_token_ctrl
// Sequencing controller for a cell-based FIFO. Two one-hot tokens walk the
// N_CELLS storage cells: the put token marks the next cell to write, the get
// token the oldest occupied cell. Per-cell full flags live here (the cells only
// hold data); full, empty and the occupancy count are derived from them.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_token_ctrl_if.slave: put_req/get_req in; put_en_o, get_en_o,
//          put_ack, get_ack, f_o, full, empty, count, ovf, udf out
// -----------------------------------------------------------------------------
module fifo_token_ctrl #(
  parameter int N_CELLS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_token_ctrl_if.slave  bus
);
  localparam int CW = $clog2(N_CELLS + 1);

  logic [N_CELLS-1:0] put_tok_q, put_tok_d;
  logic [N_CELLS-1:0] get_tok_q, get_tok_d;
  logic [N_CELLS-1:0] f_q, f_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, udf_q;

  logic               full_w, empty_w;
  logic               put_ack_w, get_ack_w;
  logic [N_CELLS-1:0] put_en_w, get_en_w;

  assign full_w    = &f_q;
  assign empty_w   = ~|f_q;

  // When full only the get can win, when empty only the put can win, so a
  // simultaneous put and get always address two different cells.
  assign put_ack_w = bus.put_req & ~full_w;
  assign get_ack_w = bus.get_req & ~empty_w;

  assign put_en_w  = put_ack_w ? put_tok_q : '0;
  assign get_en_w  = get_ack_w ? get_tok_q : '0;

  // Per-cell flag next state: set by this cell's write enable, cleared by its
  // read enable. Both never hit the same cell in one cycle.
  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_flag
    assign f_d[gi] = (f_q[gi] | put_en_w[gi]) & ~get_en_w[gi];
  end

  always_comb begin
    put_tok_d = put_tok_q;
    get_tok_d = get_tok_q;
    count_d   = count_q;
    // Rotate left with wrap from the top cell back to cell 0.
    if (put_ack_w) put_tok_d = {put_tok_q[N_CELLS-2:0], put_tok_q[N_CELLS-1]};
    if (get_ack_w) get_tok_d = {get_tok_q[N_CELLS-2:0], get_tok_q[N_CELLS-1]};
    case ({put_ack_w, get_ack_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      put_tok_q <= N_CELLS'(1);
      get_tok_q <= N_CELLS'(1);
      f_q       <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      put_tok_q <= put_tok_d;
      get_tok_q <= get_tok_d;
      f_q       <= f_d;
      count_q   <= count_d;
      // Refused requests are flagged one cycle later, once per request cycle.
      ovf_q     <= bus.put_req & full_w;
      udf_q     <= bus.get_req & empty_w;
    end
  end

  assign bus.put_en_o = put_en_w;
  assign bus.get_en_o = get_en_w;
  assign bus.put_ack  = put_ack_w;
  assign bus.get_ack  = get_ack_w;
  assign bus.f_o      = f_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule

// File: tb/tb_fifo_token_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_token_ctrl
// Drives a 16-cell and a 2-cell controller. The reference model is a queue of
// cell indices per instance: a put occupies cell (puts_so_far mod N), a get
// must release the cell at the head of the queue, and the flag vector is the
// set of cells currently in the queue.
// -----------------------------------------------------------------------------
module tb_fifo_token_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_token_ctrl_if #(.N_CELLS(16)) if16 ();
  fifo_token_ctrl_if #(.N_CELLS(2))  if2  ();

  fifo_token_ctrl #(.N_CELLS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  fifo_token_ctrl #(.N_CELLS(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int total = 0;
  int bad   = 0;

  int NC [2] = '{16, 2};
  int puts [2];
  int sb [2][$];
  bit ovf_e [2];
  bit udf_e [2];

  // Observed values, zero-extended to a common width.
  logic [15:0] o_pen, o_gen, o_f;
  logic [7:0]  o_cnt;
  logic        o_pa, o_ga, o_full, o_empty, o_ovf, o_udf;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic grab(input int k);
    if (k == 0) begin
      o_pen = if16.put_en_o; o_gen = if16.get_en_o; o_f = if16.f_o;
      o_cnt = 8'(if16.count); o_pa = if16.put_ack; o_ga = if16.get_ack;
      o_full = if16.full; o_empty = if16.empty; o_ovf = if16.ovf; o_udf = if16.udf;
    end else begin
      o_pen = 16'(if2.put_en_o); o_gen = 16'(if2.get_en_o); o_f = 16'(if2.f_o);
      o_cnt = 8'(if2.count); o_pa = if2.put_ack; o_ga = if2.get_ack;
      o_full = if2.full; o_empty = if2.empty; o_ovf = if2.ovf; o_udf = if2.udf;
    end
  endtask

  function automatic logic [15:0] occ_mask(input int k);
    logic [15:0] m = '0;
    foreach (sb[k][i]) m[sb[k][i]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      puts[k] = 0; sb[k].delete(); ovf_e[k] = 0; udf_e[k] = 0;
    end
  endtask

  // Registered-state checks against the model.
  task automatic check_state(input int k);
    string n = $sformatf("n%0d_", NC[k]);
    grab(k);
    chk({n, "count"}, 32'(o_cnt), sb[k].size());
    chk({n, "f_o"}, 32'(o_f), 32'(occ_mask(k)));
    chk({n, "full"}, 32'(o_full), 32'(sb[k].size() == NC[k]));
    chk({n, "empty"}, 32'(o_empty), 32'(sb[k].size() == 0));
    chk({n, "ovf"}, 32'(o_ovf), 32'(ovf_e[k]));
    chk({n, "udf"}, 32'(o_udf), 32'(udf_e[k]));
    chk({n, "popcount"}, $countones(o_f), 32'(o_cnt));
  endtask

  // One clock cycle: drive at the falling edge, check the combinational
  // handshake shortly after, update the model at the rising edge and check
  // the registered state shortly after that.
  task automatic cyc(input bit p16, input bit g16, input bit p2, input bit g2);
    bit p [2];
    bit g [2];
    bit pa [2];
    bit ga [2];
    p[0] = p16; g[0] = g16; p[1] = p2; g[1] = g2;
    @(negedge clk);
    if16.put_req = p16; if16.get_req = g16;
    if2.put_req  = p2;  if2.get_req  = g2;
    #1;
    for (int k = 0; k < 2; k++) begin
      string n = $sformatf("n%0d_", NC[k]);
      bit is_full, is_empty;
      is_full  = (sb[k].size() == NC[k]);
      is_empty = (sb[k].size() == 0);
      pa[k] = p[k] & ~is_full;
      ga[k] = g[k] & ~is_empty;
      grab(k);
      chk({n, "put_ack"}, 32'(o_pa), 32'(pa[k]));
      chk({n, "get_ack"}, 32'(o_ga), 32'(ga[k]));
      chk({n, "put_en"}, 32'(o_pen), pa[k] ? (32'd1 << (puts[k] % NC[k])) : 32'd0);
      chk({n, "get_en"}, 32'(o_gen), ga[k] ? (32'd1 << sb[k][0]) : 32'd0);
      chk({n, "put_en_vs_f"}, 32'(o_pen & o_f), 0);
      chk({n, "get_en_vs_f"}, 32'(o_gen & ~o_f), 0);
      ovf_e[k] = p[k] & is_full;
      udf_e[k] = g[k] & is_empty;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ga[k]) void'(sb[k].pop_front());
      if (pa[k]) begin
        sb[k].push_back(puts[k] % NC[k]);
        puts[k]++;
      end
    end
    #1;
    check_state(0);
    check_state(1);
  endtask

  initial begin
    if16.put_req = 1'b0; if16.get_req = 1'b0;
    if2.put_req  = 1'b0; if2.get_req  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, idle cycle.
    check_state(0);
    check_state(1);
    cyc(0, 0, 0, 0);
    $display("step reset: count16=%0d empty16=%0b", if16.count, if16.empty);

    // 16 puts walk put_en_o across all cells, then one refused put.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
    $display("step fill: count16=%0d full16=%0b", if16.count, if16.full);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    $display("step overflow: ovf pulse checked");

    // 16 gets walk get_en_o, then one refused get.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
    $display("step drain: count16=%0d empty16=%0b", if16.count, if16.empty);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    $display("step underflow: udf pulse checked");

    // Full with both requests: get only, then both.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    $display("step full_both: count16=%0d", if16.count);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
    // Empty with both requests: put only.
    cyc(1, 1, 0, 0);
    $display("step empty_both: count16=%0d", if16.count);

    // Steady state at 5 with simultaneous traffic; tokens wrap twice.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, 0, 0);
    $display("step stream: count16=%0d puts16=%0d", if16.count, puts[0]);

    // Asynchronous reset mid-cycle with count 7, tokens at cells 9 and 2.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0);
    chk("pre_reset_count", 32'(if16.count), 7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state(0);
    chk("rst_put_en", 32'(if16.put_en_o), 0);
    chk("rst_get_en", 32'(if16.get_en_o), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0);
    $display("step async_reset: count16=%0d f16=%0h", if16.count, if16.f_o);

    // Random traffic on both instances.
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
          1'($urandom % 2), 1'($urandom % 2));
    end
    $display("step random: puts16=%0d puts2=%0d", puts[0], puts[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
